// File: rtl/p2s_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out with a generated bit clock and frame strobe.
module p2s_serializer #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 2,
  parameter int MSB_FIRST = 1,
  parameter int GAP_CYC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_frame,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(DIV);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYC > 0) ? GAP : IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from next state so they register in step with it
    frame_d = (state_d == SHIFT);
    data_d  = frame_d && ((MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0]);
    sclk_d  = frame_d && (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_data  = data_q;
  assign ser_clk   = sclk_q;
  assign ser_frame = frame_q;
  assign done      = done_q;
endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three configurations, each with a cycle-level
// expected-waveform queue model, a receiver model, directed and random stimulus.
module tb_p2s_serializer;
  localparam int NC = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NC; g++) begin : c
    localparam int W = (g == 2) ? 6 : 4;
    localparam int D = (g == 2) ? 4 : 2;
    localparam int M = (g == 1) ? 0 : 1;
    localparam int G = (g == 0) ? 0 : (g == 1) ? 3 : 1;

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready, ser_data, ser_clk, ser_frame, done;
    // entry = {ser_data, ser_clk, ser_frame, done, in_ready} for one cycle
    logic [4:0]   q[$];
    logic [W-1:0] rx_sh, rx_last;
    int           rx_cnt;

    p2s_serializer #(.WIDTH(W), .DIV(D), .MSB_FIRST(M), .GAP_CYC(G)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .ser_data(ser_data), .ser_clk(ser_clk),
      .ser_frame(ser_frame), .done(done)
    );

    // On an accept, lay out the whole expected waveform of the word.
    initial forever begin
      @(posedge clk);
      if (rst_n) begin
        logic [4:0] cur;
        cur = (q.size() > 0) ? q[0] : 5'b00001;
        if (q.size() > 0) void'(q.pop_front());
        if (in_valid && cur[0]) begin
          for (int i = 0; i < W; i++)
            for (int d = 0; d < D; d++)
              q.push_back({in_data[(M != 0) ? W - 1 - i : i], (d >= D / 2), 1'b1, 1'b0, 1'b0});
          q.push_back({4'b0001, (G == 0)});
          for (int j = 1; j < G; j++) q.push_back(5'b00000);
        end
      end
    end

    initial forever begin
      @(negedge rst_n);
      q.delete();
    end

    initial forever begin
      @(negedge clk);
      if (chk_en)
        chk($sformatf("cfg%0d outputs", g),
            {27'b0, ser_data, ser_clk, ser_frame, done, in_ready},
            {27'b0, (rst_n && q.size() > 0) ? q[0] : 5'b00001});
    end

    // Receiver: samples on ser_clk rise, keeps a word only if the frame ends with done.
    initial begin
      logic pc, pf;
      pc = 1'b0;
      pf = 1'b0;
      rx_cnt = 0;
      forever begin
        @(negedge clk);
        if (ser_clk && !pc)
          rx_sh = (M != 0) ? {rx_sh[W-2:0], ser_data} : {ser_data, rx_sh[W-1:1]};
        if (pf && !ser_frame && done) begin
          rx_last = rx_sh;
          rx_cnt++;
        end
        pc = ser_clk;
        pf = ser_frame;
      end
    end
  end

  initial begin
    logic [7:0] dv, cv, fv;
    int n0, dn;
    c[0].in_valid = 1'b0; c[0].in_data = '0;
    c[1].in_valid = 1'b0; c[1].in_data = '0;
    c[2].in_valid = 1'b0; c[2].in_data = '0;
    dv = '0; cv = '0; fv = '0;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    nedge();
    chk("reset ready", c[0].in_ready, 1);
    chk("reset outs", {c[0].ser_data, c[0].ser_clk, c[0].ser_frame, c[0].done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      nedge();
      chk("idle outs", {c[0].ser_data, c[0].ser_clk, c[0].ser_frame, c[0].done}, 0);
    end

    // Single word MSB first
    c[0].in_data = 4'b1011; c[0].in_valid = 1'b1;
    @(posedge clk); #1 c[0].in_valid = 1'b0; c[0].in_data = 4'b0000;
    n0 = c[0].rx_cnt;
    for (int i = 0; i < 8; i++) begin
      nedge();
      dv = {dv[6:0], c[0].ser_data};
      cv = {cv[6:0], c[0].ser_clk};
      fv = {fv[6:0], c[0].ser_frame};
    end
    chk("msb data", dv, 8'b11001111);
    chk("msb clk", cv, 8'b01010101);
    chk("msb frame", fv, 8'hFF);
    nedge();
    chk("msb done", c[0].done, 1);
    chk("msb frame end", c[0].ser_frame, 0);
    chk("msb ready", c[0].in_ready, 1);
    chk("msb rx", c[0].rx_last, 4'b1011);
    chk("msb rx count", c[0].rx_cnt - n0, 1);

    // Back-to-back with in_valid held
    c[0].in_data = 4'hA; c[0].in_valid = 1'b1;
    @(posedge clk); #1 c[0].in_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      nedge();
      fv = {fv[6:0], c[0].ser_frame};
    end
    chk("b2b frame1", fv, 8'hFF);
    nedge();
    chk("b2b done1", c[0].done, 1);
    chk("b2b ready", c[0].in_ready, 1);
    chk("b2b frame gap", c[0].ser_frame, 0);
    chk("b2b rx A", c[0].rx_last, 4'hA);
    @(posedge clk); #1 c[0].in_valid = 1'b0;
    nedge();
    chk("b2b frame2", c[0].ser_frame, 1);
    repeat (7) nedge();
    nedge();
    chk("b2b done2", c[0].done, 1);
    chk("b2b rx 5", c[0].rx_last, 4'h5);

    // LSB first, busy input ignored, gap of 3
    c[1].in_data = 4'b0001; c[1].in_valid = 1'b1;
    @(posedge clk); #1 c[1].in_valid = 1'b0;
    n0 = c[1].rx_cnt;
    for (int i = 1; i <= 8; i++) begin
      nedge();
      dv = {dv[6:0], c[1].ser_data};
      if (i == 3) begin
        chk("busy ready", c[1].in_ready, 0);
        c[1].in_data = 4'hF; c[1].in_valid = 1'b1;
      end
      if (i == 5) c[1].in_valid = 1'b0;
    end
    chk("lsb data", dv, 8'b11000000);
    nedge();
    chk("gap done", c[1].done, 1);
    chk("gap ready at done", c[1].in_ready, 0);
    for (int j = 1; j <= 3; j++) begin
      nedge();
      chk($sformatf("gap ready +%0d", j), c[1].in_ready, (j == 3) ? 1 : 0);
    end
    repeat (4) nedge();
    chk("lsb rx", c[1].rx_last, 4'b0001);
    chk("busy one frame", c[1].rx_cnt - n0, 1);
    chk("busy no frame", c[1].ser_frame, 0);

    // Reset during the second bit
    c[0].in_data = 4'hC; c[0].in_valid = 1'b1;
    @(posedge clk); #1 c[0].in_valid = 1'b0;
    n0 = c[0].rx_cnt;
    repeat (3) nedge();
    #1 rst_n = 1'b0;
    #1;
    chk("abort outs", {c[0].ser_data, c[0].ser_clk, c[0].ser_frame, c[0].done}, 0);
    chk("abort ready", c[0].in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      nedge();
      dn += int'(c[0].done);
    end
    chk("abort no done", dn, 0);
    chk("abort no word", c[0].rx_cnt - n0, 0);
    c[0].in_data = 4'hC; c[0].in_valid = 1'b1;
    @(posedge clk); #1 c[0].in_valid = 1'b0;
    repeat (9) nedge();
    chk("after abort done", c[0].done, 1);
    chk("after abort rx", c[0].rx_last, 4'hC);
    chk("after abort count", c[0].rx_cnt - n0, 1);

    // Random traffic on all configurations, with two short resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst_n = (i != 700 && i != 1100);
      c[0].in_valid = 1'($urandom_range(0, 1)); c[0].in_data = 4'($urandom);
      c[1].in_valid = 1'($urandom_range(0, 1)); c[1].in_data = 4'($urandom);
      c[2].in_valid = 1'($urandom_range(0, 1)); c[2].in_data = 6'($urandom);
    end
    @(posedge clk); #1;
    c[0].in_valid = 1'b0; c[1].in_valid = 1'b0; c[2].in_valid = 1'b0;
    repeat (40) nedge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
